// File: rtl/flash_sequencer.sv
// flash_sequencer: turns divider ticks into vblank-aligned pattern/blink updates with a req/ack handshake.
// Optional FLASH_SEQ_HOLD_EN adds a hold input that masks incoming ticks.
module flash_sequencer #(
    parameter int PAT_W    = 3,
    parameter int PAT_LAST = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             vblank_start,
    input  logic             upd_ack,
    input  logic             clr_ovr,
`ifdef FLASH_SEQ_HOLD_EN
    input  logic             hold,
`endif
    output logic [PAT_W-1:0] pat_idx,
    output logic             blink,
    output logic             upd_req,
    output logic             ovr
);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] WAIT_VB = 2'b01;
    localparam logic [1:0] REQ     = 2'b10;

    localparam logic [PAT_W-1:0] LAST = PAT_W'(PAT_LAST);

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             blink_q, blink_d;
    logic             pend_q, pend_d;
    logic             ovr_q, ovr_d;
    logic             tick_eff;

`ifdef FLASH_SEQ_HOLD_EN
    assign tick_eff = tick & ~hold;
`else
    assign tick_eff = tick;
`endif

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        blink_d = blink_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q & ~clr_ovr;
        // A tick during an update in flight is queued once; a second one overruns.
        if (tick_eff && state_q != IDLE) begin
            if (pend_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end
        unique case (state_q)
            IDLE: begin
                if (tick_eff) begin
                    state_d = WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (vblank_start) begin
                    state_d = REQ;
                    pat_d   = (pat_q == LAST) ? '0 : pat_q + 1'b1;
                    blink_d = ~blink_q;
                end
            end
            REQ: begin
                if (upd_ack) begin
                    state_d = (pend_q || tick_eff) ? WAIT_VB : IDLE;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            blink_q <= 1'b0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            blink_q <= blink_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    // REQ encoding is a single bit so the request comes straight off a flop.
    assign upd_req = state_q[1];
    assign pat_idx = pat_q;
    assign blink   = blink_q;
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_flash_sequencer.sv
// tb_flash_sequencer: vector table plus hand sequences, expectations queued and popped per cycle.
// Build with +define+FLASH_SEQ_HOLD_EN to also exercise the hold input.
module tb_flash_sequencer;

    typedef struct packed {
        logic [2:0] pat;
        logic       blink;
        logic       req;
        logic       ovr;
    } out_t;

    typedef struct {
        logic tk;
        logic vb;
        logic ack;
        logic clr;
        out_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       vblank_start = 1'b0;
    logic       upd_ack = 1'b0;
    logic       clr_ovr = 1'b0;
    logic       hold = 1'b0;
    logic [2:0] pat_idx;
    logic       blink;
    logic       upd_req;
    logic       ovr;

    int   checks = 0;
    int   errors = 0;
    out_t sb[$];
    vec_t tbl[$];

    flash_sequencer #(.PAT_W(3), .PAT_LAST(7)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .vblank_start (vblank_start),
        .upd_ack      (upd_ack),
        .clr_ovr      (clr_ovr),
`ifdef FLASH_SEQ_HOLD_EN
        .hold         (hold),
`endif
        .pat_idx      (pat_idx),
        .blink        (blink),
        .upd_req      (upd_req),
        .ovr          (ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic out_t mk(input int p, input int b, input int r, input int o);
        out_t t;
        t.pat   = 3'(p);
        t.blink = b[0];
        t.req   = r[0];
        t.ovr   = o[0];
        return t;
    endfunction

    task automatic check(input string nm);
        out_t got;
        out_t e;
        got = {pat_idx, blink, upd_req, ovr};
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got pat=%0d blink=%b req=%b ovr=%b, want pat=%0d blink=%b req=%b ovr=%b",
                     nm, got.pat, got.blink, got.req, got.ovr, e.pat, e.blink, e.req, e.ovr);
        end
    endtask

    task automatic step(input logic tk, input logic vb, input logic ack,
                        input logic clr, input out_t e, input string nm);
        @(negedge clk);
        tick = tk;
        vblank_start = vb;
        upd_ack = ack;
        clr_ovr = clr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check(nm);
    endtask

    function automatic void add(input logic tk, input logic vb, input logic ack,
                                input logic clr, input out_t e);
        vec_t v;
        v.tk = tk;
        v.vb = vb;
        v.ack = ack;
        v.clr = clr;
        v.exp = e;
        tbl.push_back(v);
    endfunction

    initial begin
        // wrap: updates 2..8 after the first hand-written one
        for (int k = 2; k <= 8; k++) begin
            add(1, 0, 0, 0, mk((k - 1) % 8, (k - 1) % 2, 0, 0));
            add(0, 1, 0, 0, mk(k % 8, k % 2, 1, 0));
            add(0, 0, 1, 0, mk(k % 8, k % 2, 0, 0));
        end
        // ticks during handshake, overrun, clear
        add(1, 0, 0, 0, mk(0, 0, 0, 0));
        add(0, 1, 0, 0, mk(1, 1, 1, 0));
        add(1, 0, 0, 0, mk(1, 1, 1, 0));
        add(1, 0, 0, 0, mk(1, 1, 1, 1));
        add(0, 0, 1, 0, mk(1, 1, 0, 1));
        add(0, 1, 0, 0, mk(2, 0, 1, 1));
        add(0, 0, 0, 1, mk(2, 0, 1, 0));
        add(0, 0, 1, 0, mk(2, 0, 0, 0));
        add(0, 1, 0, 0, mk(2, 0, 0, 0));
        add(0, 0, 1, 0, mk(2, 0, 0, 0));
        // tick with vblank in IDLE
        add(1, 1, 0, 0, mk(2, 0, 0, 0));
        add(0, 0, 0, 0, mk(2, 0, 0, 0));
        add(0, 1, 0, 0, mk(3, 1, 1, 0));
        // tick with ack in REQ
        add(1, 0, 1, 0, mk(3, 1, 0, 0));
        add(0, 1, 0, 0, mk(4, 0, 1, 0));
        add(0, 0, 1, 0, mk(4, 0, 0, 0));
        add(0, 1, 0, 0, mk(4, 0, 0, 0));
        // tick with vblank in WAIT_VB
        add(1, 0, 0, 0, mk(4, 0, 0, 0));
        add(1, 1, 0, 0, mk(5, 1, 1, 0));
        add(0, 0, 1, 0, mk(5, 1, 0, 0));
        add(0, 1, 0, 0, mk(6, 0, 1, 0));
        add(0, 0, 1, 0, mk(6, 0, 0, 0));
        // overrun set coinciding with clear
        add(1, 0, 0, 0, mk(6, 0, 0, 0));
        add(1, 0, 0, 0, mk(6, 0, 0, 0));
        add(1, 0, 0, 1, mk(6, 0, 0, 1));
        add(0, 0, 0, 1, mk(6, 0, 0, 0));
        add(0, 1, 0, 0, mk(7, 1, 1, 0));
        add(0, 0, 1, 0, mk(7, 1, 0, 0));
        add(0, 1, 0, 0, mk(0, 0, 1, 0));

        // reset state
        #12;
        sb.push_back(mk(0, 0, 0, 0));
        check("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // first update: tick at cycle 10, vblank at 20, ack at 25
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, mk(0, 0, 0, 0), "pre_tick");
        step(1, 0, 0, 0, mk(0, 0, 0, 0), "tick10");
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, mk(0, 0, 0, 0), "wait_vb");
        step(0, 1, 0, 0, mk(1, 1, 1, 0), "vb20");
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, mk(1, 1, 1, 0), "req_hold");
        step(0, 0, 1, 0, mk(1, 1, 0, 0), "ack25");
        step(0, 1, 0, 0, mk(1, 1, 0, 0), "idle_vb_ignored");

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].tk, tbl[i].vb, tbl[i].ack, tbl[i].clr, tbl[i].exp,
                 $sformatf("vec%0d", i));
        end

        // reach pat_idx=5 with upd_req and ovr set, then reset mid-handshake
        step(0, 0, 1, 0, mk(0, 0, 0, 0), "rst_prep_ack");
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0, 0, mk(k - 1, (k - 1) % 2, 0, 0), "rst_prep_tick");
            step(0, 1, 0, 0, mk(k, k % 2, 1, 0), "rst_prep_vb");
            step(0, 0, 1, 0, mk(k, k % 2, 0, 0), "rst_prep_ack");
        end
        step(1, 0, 0, 0, mk(4, 0, 0, 0), "rst_prep_tick");
        step(0, 1, 0, 0, mk(5, 1, 1, 0), "rst_prep_vb5");
        step(1, 0, 0, 0, mk(5, 1, 1, 0), "rst_prep_pend");
        step(1, 0, 0, 0, mk(5, 1, 1, 1), "rst_prep_ovr");
        @(negedge clk);
        tick = 1'b0;
        reset = 1'b1;
        #1;
        sb.push_back(mk(0, 0, 0, 0));
        check("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(0, 1, 0, 0, mk(0, 0, 0, 0), "post_rst_idle_vb");
        step(0, 0, 1, 0, mk(0, 0, 0, 0), "post_rst_idle_ack");
        step(1, 0, 0, 0, mk(0, 0, 0, 0), "post_rst_tick");
        step(0, 1, 0, 0, mk(1, 1, 1, 0), "post_rst_vb");
        step(0, 0, 1, 0, mk(1, 1, 0, 0), "post_rst_ack");

`ifdef FLASH_SEQ_HOLD_EN
        hold = 1'b1;
        step(1, 0, 0, 0, mk(1, 1, 0, 0), "hold_tick_idle");
        hold = 1'b0;
        step(0, 1, 0, 0, mk(1, 1, 0, 0), "hold_stayed_idle");
        step(1, 0, 0, 0, mk(1, 1, 0, 0), "hold_tick");
        hold = 1'b1;
        step(1, 1, 0, 0, mk(2, 0, 1, 0), "hold_vb_completes");
        step(1, 0, 0, 0, mk(2, 0, 1, 0), "hold_tick_req");
        step(0, 0, 1, 0, mk(2, 0, 0, 0), "hold_ack_idle");
        hold = 1'b0;
        step(0, 1, 0, 0, mk(2, 0, 0, 0), "hold_no_pend");
`else
        hold = 1'b0;
`endif

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
